// File: rtl/writeback_unit.sv
// Register-file write-port producer: merges the in-order pipeline result with
// FIFO-buffered long-latency results, one registered write per cycle.
module writeback_unit #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [ADDR_W-1:0]             alu_rd,
    input  logic [DATA_W-1:0]             alu_data,
    input  logic                          ll_valid,
    output logic                          ll_ready,
    input  logic [ADDR_W-1:0]             ll_rd,
    input  logic [DATA_W-1:0]             ll_data,
    output logic                          regwrite,
    output logic [ADDR_W-1:0]             rd,
    output logic [DATA_W-1:0]             write_data,
    output logic                          stall_req,
    input  logic [ADDR_W-1:0]             rs1,
    input  logic [ADDR_W-1:0]             rs2,
    output logic                          busy1,
    output logic                          busy2,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {SEL_NONE, SEL_ALU, SEL_FIFO} sel_e;

    logic [ADDR_W-1:0] mem_rd_q   [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    sel_e sel;
    logic push, pop, full, empty, stall;

    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign ll_ready   = !full;
    assign stall      = (starve_q >= SW'(STARVE_LIMIT)) && !empty;
    assign stall_req  = stall;
    assign fifo_count = count_q;
    assign regwrite   = regwrite_q;
    assign rd         = rd_q;
    assign write_data = wdata_q;

    // Zero-index results complete the handshake but are dropped.
    assign push = ll_valid && ll_ready && (ll_rd != '0);
    assign pop  = (sel == SEL_FIFO);

    always_comb begin
        sel = SEL_NONE;
        if (stall)
            sel = SEL_FIFO;
        else if (alu_valid)
            sel = SEL_ALU;
        else if (!empty)
            sel = SEL_FIFO;
    end

    always_comb begin
        regwrite_d = 1'b0;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        case (sel)
            SEL_ALU: begin
                if (alu_rd != '0) begin
                    regwrite_d = 1'b1;
                    rd_d       = alu_rd;
                    wdata_d    = alu_data;
                end
            end
            SEL_FIFO: begin
                regwrite_d = 1'b1;
                rd_d       = mem_rd_q[rd_ptr_q];
                wdata_d    = mem_data_q[rd_ptr_q];
            end
            default: ;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (push) begin
            wr_ptr_d          = wr_ptr_q + PW'(1);
            valid_d[wr_ptr_q] = 1'b1;
        end
        if (pop) begin
            rd_ptr_d          = rd_ptr_q + PW'(1);
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
    end

    // Saturating count of cycles the pipeline wins while the buffer sits full.
    always_comb begin
        starve_d = starve_q;
        if (pop || !full)
            starve_d = '0;
        else if (sel == SEL_ALU && starve_q != SW'(STARVE_LIMIT))
            starve_d = starve_q + SW'(1);
    end

    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (valid_q[i] && mem_rd_q[i] == rs1) busy1 = 1'b1;
            if (valid_q[i] && mem_rd_q[i] == rs2) busy2 = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd_q[wr_ptr_q]   <= ll_rd;
            mem_data_q[wr_ptr_q] <= ll_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed vector bench for writeback_unit: table rows plus a wrap/ordering sequence.
module tb_writeback_unit;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_rd;
    logic [31:0] ll_data;
    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic        stall_req;
    logic [4:0]  rs1, rs2;
    logic        busy1, busy2;
    logic [2:0]  fifo_count;

    writeback_unit #(
        .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4), .STARVE_LIMIT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
        .regwrite(regwrite), .rd(rd), .write_data(write_data),
        .stall_req(stall_req),
        .rs1(rs1), .rs2(rs2), .busy1(busy1), .busy2(busy2),
        .fifo_count(fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_rw;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        logic [2:0]  e_cnt;
        logic        e_rdy;
        logic        e_st;
        logic        e_b1;
        logic        e_b2;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    task automatic add(input logic r, input logic av, input logic [4:0] ard,
                       input logic [31:0] adata, input logic lv, input logic [4:0] lrd,
                       input logic [31:0] ldata, input logic [4:0] s1, input logic [4:0] s2,
                       input logic erw, input logic [4:0] erd, input logic [31:0] ewd,
                       input logic [2:0] ecnt, input logic erdy, input logic est,
                       input logic eb1, input logic eb2);
        vec_t v;
        v.rst = r; v.av = av; v.ard = ard; v.adata = adata;
        v.lv = lv; v.lrd = lrd; v.ldata = ldata; v.rs1 = s1; v.rs2 = s2;
        v.e_rw = erw; v.e_rd = erd; v.e_wd = ewd; v.e_cnt = ecnt;
        v.e_rdy = erdy; v.e_st = est; v.e_b1 = eb1; v.e_b2 = eb2;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    initial begin
        ent_t q[$];
        ent_t e;
        logic exp_rw;
        logic [4:0] exp_rd;
        logic [31:0] exp_wd;
        logic do_pop, do_push;

        rst = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ll_valid = 1'b0; ll_rd = '0; ll_data = '0; rs1 = '0; rs2 = '0;

        // rst av ard adata lv lrd ldata rs1 rs2 | rw rd wd cnt rdy st b1 b2
        add(0,0,0,0,            0,0,0,          0,0,   0,0,0,0,1,0,0,0);
        add(0,0,0,0,            0,0,0,          0,0,   0,0,0,0,1,0,0,0);
        add(0,0,0,0,            0,0,0,          0,0,   0,0,0,0,1,0,0,0);
        add(1,1,5,32'hDEADBEEF, 0,0,0,          0,0,   1,5,32'hDEADBEEF,0,1,0,0,0);
        add(1,0,0,0,            1,7,32'h11,     7,8,   0,5,32'hDEADBEEF,1,1,0,1,0);
        add(1,0,0,0,            1,8,32'h22,     7,8,   1,7,32'h11,1,1,0,0,1);
        add(1,0,0,0,            0,0,0,          7,8,   1,8,32'h22,0,1,0,0,0);
        add(1,0,0,0,            0,0,0,          7,8,   0,8,32'h22,0,1,0,0,0);
        // fill the buffer while the pipeline keeps winning
        add(1,1,3,32'hA5A5A5A5, 1,10,32'hA0,    12,13, 1,3,32'hA5A5A5A5,1,1,0,0,0);
        add(1,1,3,32'hA5A5A5A5, 1,11,32'hA1,    12,13, 1,3,32'hA5A5A5A5,2,1,0,0,0);
        add(1,1,3,32'hA5A5A5A5, 1,12,32'hA2,    12,13, 1,3,32'hA5A5A5A5,3,1,0,1,0);
        add(1,1,3,32'hA5A5A5A5, 1,13,32'hA3,    12,13, 1,3,32'hA5A5A5A5,4,0,0,1,1);
        for (int k = 0; k < 7; k++)
            add(1,1,3,32'hA5A5A5A5, 0,0,0,      12,13, 1,3,32'hA5A5A5A5,4,0,0,1,1);
        add(1,1,3,32'hA5A5A5A5, 0,0,0,          12,13, 1,3,32'hA5A5A5A5,4,0,1,1,1);
        // forced pop; offer during the full cycle is refused, taken next cycle
        add(1,1,3,32'hA5A5A5A5, 1,14,32'hA4,    12,13, 1,10,32'hA0,3,1,0,1,1);
        add(1,1,3,32'hA5A5A5A5, 1,14,32'hA4,    12,14, 1,3,32'hA5A5A5A5,4,0,0,1,1);
        add(1,0,0,0,            0,0,0,          12,14, 1,11,32'hA1,3,1,0,1,1);
        // reset with three entries buffered
        add(0,1,9,32'h99,       1,15,32'h5,     12,14, 0,0,0,0,1,0,0,0);
        add(1,0,0,0,            0,0,0,          12,14, 0,0,0,0,1,0,0,0);
        add(1,0,0,0,            0,0,0,          12,14, 0,0,0,0,1,0,0,0);
        // index-zero results from both sources
        add(1,1,0,32'h55,       1,0,32'h66,     0,0,   0,0,0,0,1,0,0,0);
        add(1,0,0,0,            0,0,0,          0,0,   0,0,0,0,1,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; alu_valid = vecs[i].av; alu_rd = vecs[i].ard;
            alu_data = vecs[i].adata; ll_valid = vecs[i].lv; ll_rd = vecs[i].lrd;
            ll_data = vecs[i].ldata; rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d regwrite", i), 64'(regwrite), 64'(vecs[i].e_rw));
            chk($sformatf("row%0d rd", i), 64'(rd), 64'(vecs[i].e_rd));
            chk($sformatf("row%0d write_data", i), 64'(write_data), 64'(vecs[i].e_wd));
            chk($sformatf("row%0d fifo_count", i), 64'(fifo_count), 64'(vecs[i].e_cnt));
            chk($sformatf("row%0d ll_ready", i), 64'(ll_ready), 64'(vecs[i].e_rdy));
            chk($sformatf("row%0d stall_req", i), 64'(stall_req), 64'(vecs[i].e_st));
            chk($sformatf("row%0d busy1", i), 64'(busy1), 64'(vecs[i].e_b1));
            chk($sformatf("row%0d busy2", i), 64'(busy2), 64'(vecs[i].e_b2));
        end

        // Eight pushes through a depth-4 buffer: pointers wrap twice, order must hold.
        exp_rd = 5'd0;
        exp_wd = 32'd0;
        for (int c = 0; c < 11; c++) begin
            alu_valid = (c < 3);
            alu_rd    = 5'(c + 1);
            alu_data  = 32'h1000 + 32'(c);
            ll_valid  = (c < 8);
            ll_rd     = 5'(16 + c);
            ll_data   = 32'hB00 + 32'(c);
            rs1 = '0; rs2 = '0;
            do_pop  = !alu_valid && (q.size() > 0);
            do_push = ll_valid && (q.size() != 4);
            exp_rw  = 1'b0;
            if (alu_valid) begin
                exp_rw = 1'b1; exp_rd = alu_rd; exp_wd = alu_data;
            end else if (do_pop) begin
                e = q.pop_front();
                exp_rw = 1'b1; exp_rd = e.r; exp_wd = e.d;
            end
            if (do_push) begin
                e.r = ll_rd; e.d = ll_data;
                q.push_back(e);
            end
            @(posedge clk);
            #1;
            chk($sformatf("wrap%0d regwrite", c), 64'(regwrite), 64'(exp_rw));
            chk($sformatf("wrap%0d rd", c), 64'(rd), 64'(exp_rd));
            chk($sformatf("wrap%0d write_data", c), 64'(write_data), 64'(exp_wd));
            chk($sformatf("wrap%0d fifo_count", c), 64'(fifo_count), 64'(q.size()));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
